// File: rtl/debounce_edge_detector.sv
// Debounces a registered level input and reports committed edges as one-cycle strobes,
// along with a saturating count of rising commits.
module debounce_edge_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 d_in,
    input  logic                 clr,
    output logic                 level_out,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic                 ovf
);

    localparam int                RUN_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE_PEND,
        S_HIGH,
        S_FALL_PEND
    } state_t;

    state_t           state, state_nxt;
    logic [RUN_W-1:0] run_cnt, run_nxt;
    logic             rise_commit, fall_commit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_LOW;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_nxt;
        end
    end

    // A run of the opposite value must be unbroken; one contrary sample drops back to the stable state.
    always_comb begin
        state_nxt   = state;
        run_nxt     = run_cnt;
        rise_commit = 1'b0;
        fall_commit = 1'b0;
        case (state)
            S_LOW: begin
                run_nxt = '0;
                if (d_in) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt   = S_HIGH;
                        rise_commit = 1'b1;
                    end else begin
                        state_nxt = S_RISE_PEND;
                        run_nxt   = RUN_ONE;
                    end
                end
            end
            S_RISE_PEND: begin
                if (!d_in) begin
                    state_nxt = S_LOW;
                    run_nxt   = '0;
                end else if (run_cnt == RUN_LAST) begin
                    state_nxt   = S_HIGH;
                    run_nxt     = '0;
                    rise_commit = 1'b1;
                end else begin
                    run_nxt = run_cnt + 1'b1;
                end
            end
            S_HIGH: begin
                run_nxt = '0;
                if (!d_in) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt   = S_LOW;
                        fall_commit = 1'b1;
                    end else begin
                        state_nxt = S_FALL_PEND;
                        run_nxt   = RUN_ONE;
                    end
                end
            end
            S_FALL_PEND: begin
                if (d_in) begin
                    state_nxt = S_HIGH;
                    run_nxt   = '0;
                end else if (run_cnt == RUN_LAST) begin
                    state_nxt   = S_LOW;
                    run_nxt     = '0;
                    fall_commit = 1'b1;
                end else begin
                    run_nxt = run_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_LOW;
                run_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= rise_commit;
            fall_pulse <= fall_commit;
            if (rise_commit) begin
                level_out <= 1'b1;
            end else if (fall_commit) begin
                level_out <= 1'b0;
            end
        end
    end

    // clr wins over a coincident rising commit, so that commit is never counted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edge_count <= '0;
            ovf        <= 1'b0;
        end else if (clr) begin
            edge_count <= '0;
            ovf        <= 1'b0;
        end else if (rise_commit) begin
            if (&edge_count) begin
                ovf <= 1'b1;
            end else begin
                edge_count <= edge_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debounce_edge_detector.sv
// Bench for debounce_edge_detector: three instances (4-cycle/8-bit, 4-cycle/2-bit, 1-cycle/8-bit)
// driven from vector tables and hand sequences, checked through an expectation queue.
module tb_debounce_edge_detector;

    logic       clk;
    logic       rstn;
    logic       d_a, clr_a, level_a, rise_a, fall_a, ovf_a;
    logic [7:0] cnt_a;
    logic       d_b, clr_b, level_b, rise_b, fall_b, ovf_b;
    logic [1:0] cnt_b;
    logic       d_c, clr_c, level_c, rise_c, fall_c, ovf_c;
    logic [7:0] cnt_c;

    int checks;
    int failures;

    typedef struct {
        int         sel;
        logic       level;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
        logic       ovf;
        string      name;
    } exp_t;

    typedef struct {
        int         sel;
        logic       d;
        logic       c;
        logic       level;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
        logic       ovf;
    } vec_t;

    exp_t exp_q[$];
    vec_t vectors[$];

    debounce_edge_detector #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rstn(rstn), .d_in(d_a), .clr(clr_a), .level_out(level_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .edge_count(cnt_a), .ovf(ovf_a)
    );

    debounce_edge_detector #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rstn(rstn), .d_in(d_b), .clr(clr_b), .level_out(level_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .edge_count(cnt_b), .ovf(ovf_b)
    );

    debounce_edge_detector #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(8)) dut_c (
        .clk(clk), .rstn(rstn), .d_in(d_c), .clr(clr_c), .level_out(level_c),
        .rise_pulse(rise_c), .fall_pulse(fall_c), .edge_count(cnt_c), .ovf(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput();
        exp_t       e;
        logic       al, ar, af, ao;
        logic [7:0] ac;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard: no expectation queued");
            return;
        end
        e = exp_q.pop_front();
        case (e.sel)
            0:       begin al = level_a; ar = rise_a; af = fall_a; ac = cnt_a;         ao = ovf_a; end
            1:       begin al = level_b; ar = rise_b; af = fall_b; ac = {6'b0, cnt_b}; ao = ovf_b; end
            default: begin al = level_c; ar = rise_c; af = fall_c; ac = cnt_c;         ao = ovf_c; end
        endcase
        if (al !== e.level || ar !== e.rise || af !== e.fall || ac !== e.cnt || ao !== e.ovf) begin
            failures++;
            $display("[TB] FAIL %s (dut %0d): got level=%b rise=%b fall=%b cnt=%0d ovf=%b, expected level=%b rise=%b fall=%b cnt=%0d ovf=%b",
                     e.name, e.sel, al, ar, af, ac, ao, e.level, e.rise, e.fall, e.cnt, e.ovf);
        end
    endtask

    task automatic expectNow(input int sel, input logic el, input logic er, input logic ef,
                             input logic [7:0] ec, input logic eo, input string name);
        exp_t e;
        e.sel = sel; e.level = el; e.rise = er; e.fall = ef; e.cnt = ec; e.ovf = eo; e.name = name;
        exp_q.push_back(e);
        checkOutput();
    endtask

    task automatic applyStimulus(input int sel, input logic d, input logic c, input logic el,
                                 input logic er, input logic ef, input logic [7:0] ec,
                                 input logic eo, input string name);
        exp_t e;
        @(negedge clk);
        case (sel)
            0:       begin d_a = d; clr_a = c; end
            1:       begin d_b = d; clr_b = c; end
            default: begin d_c = d; clr_c = c; end
        endcase
        e.sel = sel; e.level = el; e.rise = er; e.fall = ef; e.cnt = ec; e.ovf = eo; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic addVec(input int sel, input logic d, input logic c, input logic l,
                          input logic r, input logic f, input logic [7:0] n, input logic o);
        vec_t v;
        v.sel = sel; v.d = d; v.c = c; v.level = l; v.rise = r; v.fall = f; v.cnt = n; v.ovf = o;
        vectors.push_back(v);
    endtask

    initial begin
        int         exp_cnt;
        logic       exp_ovf;

        checks   = 0;
        failures = 0;
        rstn  = 1'b0;
        d_a = 1'b0; clr_a = 1'b0;
        d_b = 1'b0; clr_b = 1'b0;
        d_c = 1'b0; clr_c = 1'b0;

        // dut 0: clean rise, fall, aborted rise, aborted fall, clr alone, clr with commit
        addVec(0,1,0, 0,0,0,0,0); addVec(0,1,0, 0,0,0,0,0); addVec(0,1,0, 0,0,0,0,0);
        addVec(0,1,0, 1,1,0,1,0); addVec(0,1,0, 1,0,0,1,0);
        addVec(0,0,0, 1,0,0,1,0); addVec(0,0,0, 1,0,0,1,0); addVec(0,0,0, 1,0,0,1,0);
        addVec(0,0,0, 0,0,1,1,0); addVec(0,0,0, 0,0,0,1,0);
        addVec(0,1,0, 0,0,0,1,0); addVec(0,1,0, 0,0,0,1,0); addVec(0,1,0, 0,0,0,1,0);
        addVec(0,0,0, 0,0,0,1,0);
        addVec(0,1,0, 0,0,0,1,0); addVec(0,1,0, 0,0,0,1,0); addVec(0,1,0, 0,0,0,1,0);
        addVec(0,1,0, 1,1,0,2,0); addVec(0,1,0, 1,0,0,2,0);
        addVec(0,0,0, 1,0,0,2,0); addVec(0,0,0, 1,0,0,2,0); addVec(0,0,0, 1,0,0,2,0);
        addVec(0,1,0, 1,0,0,2,0);
        addVec(0,0,0, 1,0,0,2,0); addVec(0,0,0, 1,0,0,2,0); addVec(0,0,0, 1,0,0,2,0);
        addVec(0,0,0, 0,0,1,2,0);
        addVec(0,0,1, 0,0,0,0,0);
        addVec(0,1,0, 0,0,0,0,0); addVec(0,1,0, 0,0,0,0,0); addVec(0,1,0, 0,0,0,0,0);
        addVec(0,1,1, 1,1,0,0,0); addVec(0,1,0, 1,0,0,0,0);
        addVec(0,0,0, 1,0,0,0,0); addVec(0,0,0, 1,0,0,0,0); addVec(0,0,0, 1,0,0,0,0);
        addVec(0,0,0, 0,0,1,0,0);
        addVec(0,1,0, 0,0,0,0,0); addVec(0,1,0, 0,0,0,0,0); addVec(0,1,0, 0,0,0,0,0);
        addVec(0,1,0, 1,1,0,1,0);
        // dut 2: single-cycle debounce tracks d_in one edge late
        addVec(2,1,0, 1,1,0,1,0); addVec(2,0,0, 0,0,1,1,0);
        addVec(2,1,0, 1,1,0,2,0); addVec(2,0,0, 0,0,1,2,0);
        addVec(2,1,0, 1,1,0,3,0); addVec(2,1,0, 1,0,0,3,0);
        addVec(2,0,0, 0,0,1,3,0); addVec(2,0,0, 0,0,0,3,0);

        #12;
        expectNow(0, 0,0,0,0,0, "reset_a");
        expectNow(1, 0,0,0,0,0, "reset_b");
        expectNow(2, 0,0,0,0,0, "reset_c");
        @(negedge clk);
        rstn = 1'b1;

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].sel, vectors[i].d, vectors[i].c, vectors[i].level,
                          vectors[i].rise, vectors[i].fall, vectors[i].cnt, vectors[i].ovf,
                          $sformatf("vec%0d", i));
        end

        // dut 1: five commits into a 2-bit counter saturate at 3 and set ovf from the fourth
        for (int k = 1; k <= 5; k++) begin
            exp_cnt = (k < 3) ? k : 3;
            exp_ovf = (k >= 4);
            for (int j = 0; j < 3; j++)
                applyStimulus(1, 1, 0, 0, 0, 0, 8'(exp_cnt - ((k <= 3) ? 1 : 0)),
                              (k >= 5), $sformatf("sat_rise_wait%0d", k));
            applyStimulus(1, 1, 0, 1, 1, 0, 8'(exp_cnt), exp_ovf, $sformatf("sat_commit%0d", k));
            for (int j = 0; j < 3; j++)
                applyStimulus(1, 0, 0, 1, 0, 0, 8'(exp_cnt), exp_ovf, $sformatf("sat_fall_wait%0d", k));
            applyStimulus(1, 0, 0, 0, 0, 1, 8'(exp_cnt), exp_ovf, $sformatf("sat_fall%0d", k));
        end
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, "sat_clr");

        // dut 0 is high; enter fall-pending, then reset asynchronously mid-run
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, "fallpend1");
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, "fallpend2");
        #3;
        rstn = 1'b0;
        d_a  = 1'b1;
        #1;
        expectNow(0, 0,0,0,0,0, "async_reset");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, "in_reset1");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, "in_reset2");
        #2;
        rstn = 1'b1;
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, "post_reset1");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, "post_reset2");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, "post_reset3");
        applyStimulus(0, 1, 0, 1, 1, 0, 1, 0, "post_reset_commit");
        applyStimulus(0, 1, 0, 1, 0, 0, 1, 0, "post_reset_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
